// File: rtl/usb_ep_in_buffer.sv
// rtl/usb_ep_in_buffer.sv - bulk IN endpoint circular buffer with commit/rewind and ZLP support
module usb_ep_in_buffer #(
  parameter int EP_NUM = 2,
  parameter int ADDR_W = 11,
  parameter int HS_MPS = 512,
  parameter int FS_MPS = 64
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic            busreset_i,
  input  logic            highspeed_i,
  input  logic            wr_en_i,
  input  logic [7:0]      wr_dat_i,
  input  logic            flush_i,
  output logic            full_o,
  output logic [ADDR_W:0] level_o,
  input  logic [3:0]      endpt_i,
  input  logic            txact_i,
  input  logic            txpop_i,
  input  logic            txpktfin_i,
  output logic [7:0]      txdat_o,
  output logic [11:0]     txdat_len_o,
  output logic            txcork_o,
  output logic            txval_o
);

  localparam int DEPTH_N = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  logic [7:0] mem [0:DEPTH_N-1];

  state_t          state_q, state_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_base_q, rd_base_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [11:0]     len_q, len_d;
  logic [11:0]     rem_q, rem_d;
  logic            zlp_pend_q, zlp_pend_d;
  logic            last_full_q, last_full_d;
  logic            flush_pend_q, flush_pend_d;
  logic            full_q, full_d;
  logic [ADDR_W:0] level_q, level_d;
  logic            txact_q;

  logic [ADDR_W:0] avail;
  logic [ADDR_W:0] avail_post;
  logic [11:0]     avail_len;
  logic [11:0]     mps;
  logic [11:0]     offer_len;
  logic            wr_ok;
  logic            txact_rise;
  logic            ep_hit;
  logic            commit;

  // Bytes not yet handed out in the current packet, and the length the next IN would carry.
  always_comb begin
    avail      = wr_ptr_q - rd_ptr_q;
    avail_len  = 12'(avail);
    mps        = highspeed_i ? 12'(HS_MPS) : 12'(FS_MPS);
    offer_len  = (avail_len < mps) ? avail_len : mps;
    wr_ok      = wr_en_i & ~full_q & ~busreset_i;
    txact_rise = txact_i & ~txact_q;
    ep_hit     = (endpt_i == 4'(EP_NUM));
  end

  // Buffer storage; a write while full never reaches the array.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= wr_dat_i;
    end
  end

  // Next-state: packet FSM, pointer movement, commit/rewind and ZLP bookkeeping.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rd_base_d    = rd_base_q;
    len_d        = len_q;
    rem_d        = rem_q;
    zlp_pend_d   = zlp_pend_q;
    last_full_d  = last_full_q;
    flush_pend_d = flush_pend_q;
    commit       = 1'b0;
    avail_post   = '0;
    level_d      = '0;
    full_d       = 1'b0;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (txact_rise && ep_hit) begin
          len_d   = offer_len;
          rem_d   = offer_len;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (txpop_i && rem_q != 12'd0) begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          rem_d    = rem_q - 12'd1;
        end
        // A pktfin coinciding with the txact fall is still an ACKed packet.
        if (txpktfin_i) begin
          commit      = 1'b1;
          rd_base_d   = rd_ptr_d;
          last_full_d = (len_q == mps);
          if (len_q == 12'd0) begin
            zlp_pend_d = 1'b0;
          end
          state_d = ST_WAIT;
        end else if (!txact_i) begin
          // Host did not ACK: resend the same bytes on the retry.
          rd_ptr_d = rd_base_q;
          rem_d    = 12'd0;
          state_d  = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!txact_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A flush that arrived with data still queued resolves once the last packet commits.
    avail_post = wr_ptr_d - rd_ptr_d;
    if (commit && flush_pend_q && avail_post == '0) begin
      flush_pend_d = 1'b0;
      if (last_full_d) begin
        zlp_pend_d = 1'b1;
      end
    end

    if (flush_i) begin
      if (state_q != ST_SEND && avail == '0) begin
        if (last_full_q) begin
          zlp_pend_d = 1'b1;
        end
      end else begin
        flush_pend_d = 1'b1;
      end
    end

    if (busreset_i) begin
      state_d      = ST_IDLE;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      rd_base_d    = '0;
      len_d        = 12'd0;
      rem_d        = 12'd0;
      zlp_pend_d   = 1'b0;
      last_full_d  = 1'b0;
      flush_pend_d = 1'b0;
    end

    level_d = wr_ptr_d - rd_base_d;
    full_d  = (level_d == DEPTH);
  end

  // State and pointer registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rd_base_q    <= '0;
      len_q        <= 12'd0;
      rem_q        <= 12'd0;
      zlp_pend_q   <= 1'b0;
      last_full_q  <= 1'b0;
      flush_pend_q <= 1'b0;
      full_q       <= 1'b0;
      level_q      <= '0;
      txact_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_base_q    <= rd_base_d;
      len_q        <= len_d;
      rem_q        <= rem_d;
      zlp_pend_q   <= zlp_pend_d;
      last_full_q  <= last_full_d;
      flush_pend_q <= flush_pend_d;
      full_q       <= full_d;
      level_q      <= level_d;
      txact_q      <= txact_i;
    end
  end

  // Controller-facing outputs: live offer outside a packet, latched packet inside one.
  always_comb begin
    full_o      = full_q;
    level_o     = level_q;
    txdat_o     = 8'd0;
    txval_o     = 1'b0;
    txdat_len_o = offer_len;
    txcork_o    = ~((avail != '0) | zlp_pend_q);
    if (state_q == ST_SEND) begin
      txdat_o     = mem[rd_ptr_q[ADDR_W-1:0]];
      txval_o     = (rem_q != 12'd0);
      txdat_len_o = len_q;
      txcork_o    = 1'b0;
    end
  end

endmodule

// File: tb/tb_usb_ep_in_buffer.sv
// tb/tb_usb_ep_in_buffer.sv - self-checking bench for usb_ep_in_buffer
module tb_usb_ep_in_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busreset = 1'b0;
  logic        highspeed = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_dat = 8'd0;
  logic        flush = 1'b0;
  logic        full;
  logic [11:0] level;
  logic [3:0]  endpt = 4'd0;
  logic        txact = 1'b0;
  logic        txpop = 1'b0;
  logic        txpktfin = 1'b0;
  logic [7:0]  txdat;
  logic [11:0] txlen;
  logic        txcork;
  logic        txval;

  int n_pass = 0;
  int n_total = 0;

  // Model: uncommitted bytes as a queue, plus packet/ZLP flags.
  logic [7:0] mq[$];
  bit m_send = 0, m_wait = 0, m_zlp = 0, m_lf = 0, m_fpend = 0, act_prev = 0;
  int m_pop = 0, m_len = 0;

  usb_ep_in_buffer dut (
    .clk_i       (clk),
    .reset_n_i   (rst_n),
    .busreset_i  (busreset),
    .highspeed_i (highspeed),
    .wr_en_i     (wr_en),
    .wr_dat_i    (wr_dat),
    .flush_i     (flush),
    .full_o      (full),
    .level_o     (level),
    .endpt_i     (endpt),
    .txact_i     (txact),
    .txpop_i     (txpop),
    .txpktfin_i  (txpktfin),
    .txdat_o     (txdat),
    .txdat_len_o (txlen),
    .txcork_o    (txcork),
    .txval_o     (txval)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Model update on each rising edge from the inputs presented during that cycle.
  initial begin : mdl
    int av, mps_m;
    bit wr_ok, commit, was_send, lf_old;
    forever begin
      @(posedge clk);
      if (!rst_n || busreset) begin
        mq.delete();
        m_send = 0; m_wait = 0; m_pop = 0; m_len = 0;
        m_zlp = 0; m_lf = 0; m_fpend = 0;
        act_prev = rst_n ? txact : 1'b0;
      end else begin
        av = mq.size() - m_pop;
        mps_m = highspeed ? 512 : 64;
        wr_ok = wr_en && (mq.size() < 2048);
        was_send = m_send;
        lf_old = m_lf;
        commit = 0;
        if (m_send) begin
          if (txpop && m_pop < m_len) m_pop++;
          if (txpktfin) begin
            repeat (m_pop) void'(mq.pop_front());
            m_lf = (m_len == mps_m);
            if (m_len == 0) m_zlp = 0;
            m_send = 0; m_wait = 1; m_pop = 0; commit = 1;
          end else if (!txact) begin
            m_send = 0; m_pop = 0;
          end
        end else if (m_wait) begin
          if (!txact) m_wait = 0;
        end else if (txact && !act_prev && endpt == 4'd2) begin
          m_send = 1; m_pop = 0;
          m_len = (av < mps_m) ? av : mps_m;
        end
        if (commit && m_fpend && (mq.size() + int'(wr_ok)) == 0) begin
          m_fpend = 0;
          if (m_lf) m_zlp = 1;
        end
        if (flush) begin
          if (!was_send && av == 0) begin
            if (lf_old) m_zlp = 1;
          end else begin
            m_fpend = 1;
          end
        end
        if (wr_ok) mq.push_back(wr_dat);
        act_prev = txact;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin : cmp
    int av, mps_m, e_len, e_cork, e_val;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        av = mq.size() - m_pop;
        mps_m = highspeed ? 512 : 64;
        if (m_send) begin
          e_len = m_len; e_cork = 0; e_val = int'(m_pop < m_len);
        end else begin
          e_len = (av < mps_m) ? av : mps_m;
          e_cork = int'(av == 0 && !m_zlp);
          e_val = 0;
        end
        chk("cyc_level", int'(level), mq.size());
        chk("cyc_full", int'(full), int'(mq.size() == 2048));
        chk("cyc_len", int'(txlen), e_len);
        chk("cyc_cork", int'(txcork), e_cork);
        chk("cyc_val", int'(txval), e_val);
        if (e_val != 0) chk("cyc_dat", int'(txdat), int'(mq[m_pop]));
        else if (!m_send) chk("cyc_dat_idle", int'(txdat), 0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_seq(input int n, input int start);
    wr_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      wr_dat = 8'((start + i) & 255);
      cyc();
    end
    wr_en = 1'b0;
  endtask

  task automatic in_start();
    endpt = 4'd2;
    txact = 1'b1;
    cyc();
  endtask

  task automatic pop_n(input int n, input int start);
    txpop = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk("pop_dat", int'(txdat), (start + i) & 255);
      cyc();
    end
    txpop = 1'b0;
  endtask

  task automatic fin();
    txpktfin = 1'b1;
    cyc();
    txpktfin = 1'b0;
    txact = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();
  endtask

  // Directed scenarios.
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_full", int'(full), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_cork", int'(txcork), 1);
    chk("rst_len", int'(txlen), 0);
    chk("rst_val", int'(txval), 0);
    chk("rst_dat", int'(txdat), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();

    // FS, 10 bytes in one packet
    highspeed = 1'b0;
    write_seq(10, 0);
    chk("t1_level", int'(level), 10);
    chk("t1_offer", int'(txlen), 10);
    chk("t1_cork", int'(txcork), 0);
    in_start();
    chk("t1_len", int'(txlen), 10);
    chk("t1_val", int'(txval), 1);
    pop_n(10, 0);
    chk("t1_val_end", int'(txval), 0);
    fin();
    chk("t1_level_end", int'(level), 0);
    chk("t1_cork_end", int'(txcork), 1);

    // HS, 600 bytes as 512 + 88, no ZLP after flush
    highspeed = 1'b1;
    write_seq(600, 8'h40);
    chk("t2_level", int'(level), 600);
    in_start();
    chk("t2_len1", int'(txlen), 512);
    pop_n(512, 8'h40);
    fin();
    chk("t2_offer2", int'(txlen), 88);
    in_start();
    chk("t2_len2", int'(txlen), 88);
    pop_n(88, 8'h40 + 512);
    fin();
    pulse_flush();
    chk("t2_cork", int'(txcork), 1);
    chk("t2_len0", int'(txlen), 0);

    // FS, exact 64 then flush -> ZLP
    highspeed = 1'b0;
    write_seq(64, 8'h80);
    pulse_flush();
    in_start();
    chk("t3_len", int'(txlen), 64);
    pop_n(64, 8'h80);
    fin();
    chk("t3_zlp_cork", int'(txcork), 0);
    chk("t3_zlp_len", int'(txlen), 0);
    in_start();
    chk("t3_zlp_val", int'(txval), 0);
    chk("t3_zlp_slen", int'(txlen), 0);
    fin();
    chk("t3_cork_end", int'(txcork), 1);

    // Abort after 7 pops, retry resends from byte 0
    write_seq(20, 8'hC0);
    in_start();
    pop_n(7, 8'hC0);
    chk("t4_level_mid", int'(level), 20);
    txact = 1'b0;
    cyc();
    chk("t4_level_ab", int'(level), 20);
    chk("t4_offer", int'(txlen), 20);
    in_start();
    chk("t4_len", int'(txlen), 20);
    pop_n(20, 8'hC0);
    fin();
    chk("t4_level_end", int'(level), 0);

    // Fill to full, drop one extra write, drain across the wrap
    highspeed = 1'b1;
    write_seq(2048, 3);
    wr_en = 1'b1;
    wr_dat = 8'hEE;
    cyc();
    wr_en = 1'b0;
    chk("t5_full", int'(full), 1);
    chk("t5_level", int'(level), 2048);
    for (int p = 0; p < 4; p++) begin
      in_start();
      chk("t5_len", int'(txlen), 512);
      pop_n(512, 3 + 512 * p);
      fin();
      if (p == 0) begin
        chk("t5_full_after", int'(full), 0);
        chk("t5_level_after", int'(level), 1536);
      end
    end
    chk("t5_level_end", int'(level), 0);

    // Foreign endpoint is ignored
    highspeed = 1'b0;
    write_seq(5, 8'h10);
    endpt = 4'd3;
    txact = 1'b1;
    cyc();
    txpop = 1'b1;
    repeat (3) cyc();
    txpop = 1'b0;
    txact = 1'b0;
    cyc();
    chk("t6_level", int'(level), 5);
    chk("t6_offer", int'(txlen), 5);
    chk("t6_val", int'(txval), 0);

    // Bus reset in the middle of a packet
    in_start();
    pop_n(2, 8'h10);
    busreset = 1'b1;
    cyc();
    busreset = 1'b0;
    chk("t7_level", int'(level), 0);
    chk("t7_cork", int'(txcork), 1);
    chk("t7_val", int'(txval), 0);
    chk("t7_len", int'(txlen), 0);
    txpop = 1'b1;
    repeat (3) cyc();
    txpop = 1'b0;
    txact = 1'b0;
    cyc();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/usb_ep_in_buffer.md
Name: usb_ep_in_buffer

Overview:
- Bulk IN endpoint buffer between application byte producers (e.g. the UART bridge) and the USB device controller transmit interface (txdat/txdat_len/txcork/txpop/txact/txpktfin).
- Stores bytes in a circular buffer and presents up to one max-packet per IN transaction.
- Commits bytes only on packet completion; rewinds on an aborted transaction so the host retry resends identical data.
- Supports a host-visible zero-length packet (ZLP) after an exact-multiple transfer.

Parameters:
- EP_NUM, 2, endpoint number this buffer answers to on endpt_i.
- ADDR_W, 11, buffer address width; depth = 2**ADDR_W bytes.
- HS_MPS, 512, max packet size at high speed.
- FS_MPS, 64, max packet size at full speed.

Ports:
- clk_i  in  1  controller clock (60 MHz UTMI domain).
- reset_n_i  in  1  asynchronous active-low reset.
- busreset_i  in  1  USB bus reset; synchronous clear of buffer and state.
- highspeed_i  in  1  selects HS_MPS (1) or FS_MPS (0).
- wr_en_i  in  1  write strobe from the application.
- wr_dat_i  in  8  write byte.
- flush_i  in  1  pulse: end of transfer; request ZLP if required.
- full_o  out  1  buffer full; writes ignored.
- level_o  out  ADDR_W+1  uncommitted bytes stored (wr_ptr - rd_base).
- endpt_i  in  4  endpoint currently addressed by the controller.
- txact_i  in  1  controller IN transaction active.
- txpop_i  in  1  controller consumes the current txdat_o byte.
- txpktfin_i  in  1  one-cycle pulse: packet ACKed by host.
- txdat_o  out  8  head byte (first-word-fall-through).
- txdat_len_o  out  12  packet length offered or latched.
- txcork_o  out  1  1 = nothing to send (controller NAKs).
- txval_o  out  1  txdat_o valid within the current packet.

Behaviour:
- Pointers are ADDR_W+1 bits with wrap bit: wr_ptr, rd_base (committed), rd_ptr (speculative). avail = wr_ptr - rd_ptr. full = (wr_ptr - rd_base) == 2**ADDR_W.
- Reset (reset_n_i=0) or busreset_i=1: all pointers 0, state IDLE, zlp_pend=0, last_full=0.
- Reset output values: full_o=0, level_o=0, txcork_o=1, txdat_len_o=0, txval_o=0, txdat_o=0.
- Write: wr_en_i & ~full stores wr_dat_i at wr_ptr and increments wr_ptr; a write while full is dropped with no side effect. full_o and level_o are registered and update the cycle after the write.
- mps = highspeed_i ? HS_MPS : FS_MPS.
- IDLE: txdat_len_o = min(avail, mps), combinationally live.
  - txcork_o = ~(avail != 0 | zlp_pend).
  - txval_o = 0.
- Transition IDLE->SEND: txact_i rising edge while endpt_i == EP_NUM. On entry, latch len = min(avail, mps) and set rem = len.
- SEND:
  - txdat_len_o = latched len; txcork_o = 0.
  - txval_o = (rem != 0).
  - txdat_o = mem[rd_ptr] (zero latency, buffer read asynchronous or prefetched).
  - txpop_i & rem != 0: rd_ptr+1, rem-1. txpop_i when rem == 0 is ignored.
  - txpktfin_i: rd_base <= rd_ptr; last_full <= (len == mps); zlp_pend <= 0 if len == 0. Transition to WAIT.
  - txact_i falls with no txpktfin_i seen: rd_ptr <= rd_base (rewind); zlp_pend unchanged; transition to IDLE.
- WAIT: return to IDLE when txact_i == 0.
- txpktfin_i and the txact_i fall in the same cycle count as success (commit wins).
- ZLP:
  - flush_i with avail == 0 and last_full == 1 sets zlp_pend.
  - flush_i with avail > 0 is remembered: after the final packet commits, if last_full == 1 and avail == 0, set zlp_pend.
  - A ZLP is offered with len = 0 and txval_o = 0.
- Writes during SEND are permitted. They affect only the next packet's length, never the latched len.
- Wrap-around: the pointer wrap bit distinguishes full from empty, and reads across the buffer end are contiguous.
- Asserting busreset_i mid-SEND discards all data, and the buffer must not emit further bytes.

Test Plan:
- FS, write 10 bytes 0x00..0x09, IN on EP2: txcork_o=0, txdat_len_o=10; 10 pops return 0x00..0x09; txpktfin -> level_o=0, txcork_o=1.
- HS, write 600 bytes: first packet len=512, second len=88. Flush after the second packet: no ZLP, txcork_o=1.
- FS, write 64 bytes then flush_i: packet len=64, then a ZLP with txcork_o=0, txdat_len_o=0; after its pktfin, txcork_o=1.
- Abort: 20 bytes, pop 7, drop txact_i without pktfin -> retry offers len=20 starting at byte 0; level_o stays 20 throughout.
- Fill 2048 bytes: full_o=1; a 2049th write is dropped. Drain across the wrap: byte order preserved, full_o=0 after the first committed packet.
- endpt_i=3 with txact_i: no state change and no pops honoured. busreset_i mid-SEND: level_o=0, txcork_o=1 next cycle.
